// File: rtl/pepo_control_unit_pkg.sv
// Shared definitions for the PEPO microprogrammed control unit: control-word bit map,
// sequencing modes, state numbers and the constant microstore.
package pepo_control_unit_pkg;

    localparam int DP_W = 34;
    localparam int UW   = 48;

    localparam int B_RF_LD     = 0;
    localparam int B_IR_LD     = 1;
    localparam int B_MAR_LD    = 2;
    localparam int B_MDR_LD    = 3;
    localparam int B_RW        = 4;
    localparam int B_MOV       = 5;
    localparam int B_FR_LD     = 6;
    localparam int B_ALU_LSB   = 7;
    localparam int B_MA_LSB    = 11;
    localparam int B_MB_LSB    = 13;
    localparam int B_MC_LSB    = 15;
    localparam int B_MD        = 17;
    localparam int B_ME        = 18;
    localparam int B_MF        = 19;
    localparam int B_MG        = 20;
    localparam int B_MH        = 21;
    localparam int B_MI        = 22;
    localparam int B_DSIZE_LSB = 23;

    // Sequencing fields sit above the datapath word: N[36:34], INV[37], CR[45:38]
    localparam int SEQ_N_LSB  = 34;
    localparam int SEQ_INV    = 37;
    localparam int SEQ_CR_LSB = 38;

    typedef enum logic [2:0] {
        N_INC    = 3'b000,
        N_JUMP   = 3'b001,
        N_DECODE = 3'b010,
        N_COND   = 3'b011,
        N_MOC    = 3'b100,
        N_LSM    = 3'b101
    } n_mode_e;

    localparam logic [5:0] S_IDLE       = 6'd0;
    localparam logic [5:0] S_FETCH_MAR  = 6'd1;
    localparam logic [5:0] S_FETCH_PC   = 6'd2;
    localparam logic [5:0] S_FETCH_WAIT = 6'd3;
    localparam logic [5:0] S_DECODE     = 6'd4;
    localparam logic [5:0] S_DP         = 6'd10;
    localparam logic [5:0] S_LS_ADDR    = 6'd20;
    localparam logic [5:0] S_LS_WAIT    = 6'd21;
    localparam logic [5:0] S_LS_WB      = 6'd22;
    localparam logic [5:0] S_B          = 6'd30;
    localparam logic [5:0] S_BL         = 6'd31;
    localparam logic [5:0] S_BL_PC      = 6'd32;
    localparam logic [5:0] S_LSM_ADDR   = 6'd40;
    localparam logic [5:0] S_LSM_WAIT   = 6'd41;
    localparam logic [5:0] S_LSM_XFER   = 6'd42;
    localparam logic [5:0] S_LSM_NEXT   = 6'd43;
    localparam logic [5:0] S_LSM_EXIT   = 6'd44;

    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_MOV    = 4'b1101;
    localparam logic [1:0] MA_PC      = 2'b01;
    localparam logic [1:0] MB_PC      = 2'b01;
    localparam logic [1:0] MB_FOUR    = 2'b10;
    localparam logic [1:0] MC_PC      = 2'b01;
    localparam logic [1:0] MC_LR      = 2'b10;
    localparam logic [1:0] DSIZE_WORD = 2'b10;

    function automatic logic [DP_W-1:0] flag(input int b);
        return DP_W'(1) << b;
    endfunction

    function automatic logic [DP_W-1:0] fld4(input logic [3:0] v, input int lsb);
        return DP_W'(v) << lsb;
    endfunction

    function automatic logic [DP_W-1:0] fld2(input logic [1:0] v, input int lsb);
        return DP_W'(v) << lsb;
    endfunction

    function automatic logic [UW-1:0] uinst(input logic [DP_W-1:0] dp, input n_mode_e n,
                                            input logic inv, input logic [5:0] cr);
        return {2'b00, 2'b00, cr, inv, n, dp};
    endfunction

    // Unlisted states are all-zero words, i.e. N_INC with no controls.
    function automatic logic [UW-1:0] microstore(input logic [5:0] st);
        logic [DP_W-1:0] mem_read;
        mem_read = flag(B_MOV) | flag(B_RW) | fld2(DSIZE_WORD, B_DSIZE_LSB);
        case (st)
            S_FETCH_MAR:  return uinst(flag(B_MAR_LD) | fld4(ALU_MOV, B_ALU_LSB)
                                       | fld2(MB_PC, B_MB_LSB), N_INC, 1'b0, 6'd0);
            S_FETCH_PC:   return uinst(mem_read | flag(B_RF_LD) | fld4(ALU_ADD, B_ALU_LSB)
                                       | fld2(MA_PC, B_MA_LSB) | fld2(MB_FOUR, B_MB_LSB)
                                       | fld2(MC_PC, B_MC_LSB), N_INC, 1'b0, 6'd0);
            // IR_LD stays up through the wait so the final load lands on the exit edge
            S_FETCH_WAIT: return uinst(mem_read | flag(B_IR_LD), N_MOC, 1'b0, 6'd0);
            S_DECODE:     return uinst('0, N_DECODE, 1'b0, 6'd0);
            S_DP:         return uinst(flag(B_RF_LD) | flag(B_MD) | flag(B_ME),
                                       N_JUMP, 1'b0, S_FETCH_MAR);
            S_LS_ADDR:    return uinst(flag(B_MAR_LD) | fld4(ALU_ADD, B_ALU_LSB) | flag(B_MF),
                                       N_INC, 1'b0, 6'd0);
            S_LS_WAIT:    return uinst(mem_read | flag(B_MDR_LD), N_MOC, 1'b0, 6'd0);
            S_LS_WB:      return uinst(flag(B_RF_LD) | flag(B_MI), N_JUMP, 1'b0, S_FETCH_MAR);
            S_B, S_BL_PC: return uinst(flag(B_RF_LD) | fld4(ALU_ADD, B_ALU_LSB)
                                       | fld2(MA_PC, B_MA_LSB) | flag(B_MG)
                                       | fld2(MC_PC, B_MC_LSB), N_JUMP, 1'b0, S_FETCH_MAR);
            S_BL:         return uinst(flag(B_RF_LD) | fld4(ALU_MOV, B_ALU_LSB)
                                       | fld2(MB_PC, B_MB_LSB) | fld2(MC_LR, B_MC_LSB),
                                       N_INC, 1'b0, 6'd0);
            S_LSM_ADDR:   return uinst(flag(B_MAR_LD) | fld4(ALU_MOV, B_ALU_LSB) | flag(B_MF),
                                       N_INC, 1'b0, 6'd0);
            S_LSM_WAIT:   return uinst(mem_read | flag(B_MDR_LD), N_MOC, 1'b0, 6'd0);
            S_LSM_XFER:   return uinst(flag(B_RF_LD) | flag(B_MAR_LD) | flag(B_MI)
                                       | flag(B_MH) | fld4(ALU_ADD, B_ALU_LSB)
                                       | fld2(MB_FOUR, B_MB_LSB), N_LSM, 1'b0, S_LSM_EXIT);
            S_LSM_NEXT:   return uinst('0, N_JUMP, 1'b0, S_LSM_WAIT);
            S_LSM_EXIT:   return uinst('0, N_JUMP, 1'b0, S_FETCH_MAR);
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/pepo_control_unit_next_state.sv
// Next-state selection for the PEPO sequencer: sequencing-mode mux plus the
// combinational instruction decoder used by the decode state.
module pepo_next_state
    import pepo_control_unit_pkg::*;
(
    input  logic [5:0] i_state,
    input  n_mode_e    i_mode,
    input  logic       i_inv,
    input  logic [5:0] i_cr,
    input  logic [3:0] i_ir_op,
    input  logic       i_cond,
    input  logic       i_moc,
    input  logic       i_lsm_detect,
    input  logic       i_lsm_end,
    output logic [5:0] o_next
);

    logic [5:0] w_inc;
    logic [5:0] w_decode;

    assign w_inc = i_state + 6'd1;

    // i_ir_op is IR[27:24]: class in [3:1], branch link bit in [0]
    always_comb begin
        w_decode = S_FETCH_MAR;
        if (i_cond) begin
            case (i_ir_op[3:1])
                3'b000, 3'b001: w_decode = S_DP;
                3'b010, 3'b011: w_decode = S_LS_ADDR;
                3'b100:         if (i_lsm_detect) w_decode = S_LSM_ADDR;
                3'b101:         w_decode = i_ir_op[0] ? S_BL : S_B;
                default:        w_decode = S_FETCH_MAR;
            endcase
        end
    end

    always_comb begin
        o_next = w_inc;
        case (i_mode)
            N_INC:    o_next = w_inc;
            N_JUMP:   o_next = i_cr;
            N_DECODE: o_next = w_decode;
            N_COND:   if (i_cond ^ i_inv) o_next = i_cr;
            N_MOC:    if (!(i_moc ^ i_inv)) o_next = i_state;
            N_LSM:    if (i_lsm_end) o_next = i_cr;
            default:  o_next = w_inc;
        endcase
    end

endmodule

// File: rtl/pepo_control_unit.sv
// PEPO microprogrammed control unit: state register, constant microstore and the
// registered control word that drives the datapath.
module pepo_control_unit
    import pepo_control_unit_pkg::*;
#(
    parameter int UWORD_W = 48,
    parameter int STATES  = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IR_OUT,
    input  logic        MOC,
    input  logic        COND,
    input  logic        LSM_DETECT,
    input  logic        LSM_END,
    output logic [33:0] cu_datapath
);

    localparam int SW = $clog2(STATES);

    logic [SW-1:0]      state_q;
    logic [UWORD_W-1:0] CTL_REG_CUI;
    logic [SW-1:0]      w_next;
    logic [UWORD_W-1:0] w_uinst;
    logic               w_unused;

    // CTL_REG_CUI always holds microstore[state_q], so its sequencing fields steer the next step
    pepo_next_state u_next_state (
        .i_state      (state_q),
        .i_mode       (n_mode_e'(CTL_REG_CUI[SEQ_N_LSB +: 3])),
        .i_inv        (CTL_REG_CUI[SEQ_INV]),
        .i_cr         (CTL_REG_CUI[SEQ_CR_LSB +: 6]),
        .i_ir_op      (IR_OUT[27:24]),
        .i_cond       (COND),
        .i_moc        (MOC),
        .i_lsm_detect (LSM_DETECT),
        .i_lsm_end    (LSM_END),
        .o_next       (w_next)
    );

    assign w_uinst = microstore(w_next);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= '0;
            CTL_REG_CUI <= '0;
        end else begin
            state_q     <= w_next;
            CTL_REG_CUI <= w_uinst;
        end
    end

    assign cu_datapath = CTL_REG_CUI[33:0];

    assign w_unused = &{1'b0, CTL_REG_CUI[UWORD_W-1:SEQ_CR_LSB+6], IR_OUT[31:28], IR_OUT[23:0]};

endmodule

// File: tb/tb_pepo_control_unit.sv
// Randomized scoreboard bench for pepo_control_unit against a behavioural state/control model.
module tb_pepo_control_unit;

    localparam int NCYC = 3000;

    localparam int RF_LD = 0, IR_LD = 1, MAR_LD = 2, MDR_LD = 3, RW = 4, MOV = 5;
    localparam int MD = 17, ME = 18, MF = 19, MG = 20, MH = 21, MI = 22;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IR_OUT;
    logic        MOC, COND, LSM_DETECT, LSM_END;
    logic [33:0] cu_datapath;

    always #5 CLK = ~CLK;

    pepo_control_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IR_OUT      (IR_OUT),
        .MOC         (MOC),
        .COND        (COND),
        .LSM_DETECT  (LSM_DETECT),
        .LSM_END     (LSM_END),
        .cu_datapath (cu_datapath)
    );

    typedef struct {
        int          st;
        logic [33:0] w;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_state;
    int   visits[64];

    function automatic logic [33:0] b(input int pos);
        logic [33:0] one;
        one = 34'd1;
        return one << pos;
    endfunction

    function automatic logic [33:0] f(input int v, input int lsb);
        logic [33:0] x;
        x = 34'(v);
        return x << lsb;
    endfunction

    // Control word expected while the machine sits in a state
    function automatic logic [33:0] exp_word(input int s);
        logic [33:0] rd;
        rd = b(MOV) | b(RW) | f(2, 23);
        case (s)
            1:       return b(MAR_LD) | f(13, 7) | f(1, 13);
            2:       return rd | b(RF_LD) | f(4, 7) | f(1, 11) | f(2, 13) | f(1, 15);
            3:       return rd | b(IR_LD);
            10:      return b(RF_LD) | b(MD) | b(ME);
            20:      return b(MAR_LD) | f(4, 7) | b(MF);
            21, 41:  return rd | b(MDR_LD);
            22:      return b(RF_LD) | b(MI);
            30, 32:  return b(RF_LD) | f(4, 7) | f(1, 11) | b(MG) | f(1, 15);
            31:      return b(RF_LD) | f(13, 7) | f(1, 13) | f(2, 15);
            40:      return b(MAR_LD) | f(13, 7) | b(MF);
            42:      return b(RF_LD) | b(MAR_LD) | b(MI) | b(MH) | f(4, 7) | f(2, 13);
            default: return 34'd0;
        endcase
    endfunction

    function automatic int decode(input logic [31:0] ir, input logic cond, input logic lsmd);
        if (!cond) return 1;
        case (ir[27:25])
            3'b000, 3'b001: return 10;
            3'b010, 3'b011: return 20;
            3'b100:         return lsmd ? 40 : 1;
            3'b101:         return ir[24] ? 31 : 30;
            default:        return 1;
        endcase
    endfunction

    function automatic int model_next(input int s, input logic [31:0] ir, input logic moc,
                                      input logic cond, input logic lsmd, input logic lend);
        case (s)
            3:          return moc ? 4 : 3;
            4:          return decode(ir, cond, lsmd);
            10, 22, 30, 32, 44: return 1;
            21:         return moc ? 22 : 21;
            41:         return moc ? 42 : 41;
            42:         return lend ? 44 : 43;
            43:         return 41;
            default:    return (s + 1) % 64;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("state", 64'(dut.state_q), 64'(e.st));
                check("ctl", 64'(cu_datapath), 64'(e.w));
            end
        end
    end

    initial begin
        #(NCYC * 10 + 2000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  rst_hold;
        int  wait_cnt;
        bit  mid_done;
        int  moc_pct;
        RESET = 1'b0;
        IR_OUT = '0; MOC = 1'b0; COND = 1'b0; LSM_DETECT = 1'b0; LSM_END = 1'b0;
        rst_hold = 0; wait_cnt = 0; mid_done = 1'b0;
        #1;
        check("rst_ctl", 64'(cu_datapath), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'd0);
        m_state = 0;
        repeat (2) @(negedge CLK);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            moc_pct = ((cyc / 256) % 2 == 1) ? 40 : 10;
            IR_OUT     = $urandom;
            COND       = ($urandom_range(0, 3) != 0);
            MOC        = ($urandom_range(0, 99) < moc_pct);
            LSM_DETECT = (IR_OUT[27:25] == 3'b100) ? ($urandom_range(0, 9) < 8)
                                                   : ($urandom_range(0, 9) == 0);
            LSM_END    = ($urandom_range(0, 99) < 35);
            visits[m_state]++;
            wait_cnt = (m_state == 3) ? wait_cnt + 1 : 0;

            if (rst_hold == 0 && ((!mid_done && m_state == 3 && wait_cnt >= 2) ||
                                  (cyc > 200 && $urandom_range(0, 199) == 0))) begin
                rst_hold = 2;
                mid_done = 1'b1;
                RESET = 1'b0;
                #1;
                check("async_rst_ctl", 64'(cu_datapath), 64'd0);
                check("async_rst_state", 64'(dut.state_q), 64'd0);
            end

            if (rst_hold > 0) begin
                RESET = 1'b0;
                rst_hold--;
                m_state = 0;
            end else begin
                RESET = 1'b1;
                m_state = model_next(m_state, IR_OUT, MOC, COND, LSM_DETECT, LSM_END);
            end
            q.push_back('{st: m_state, w: exp_word(m_state)});
            @(negedge CLK);
        end

        repeat (2) @(negedge CLK);
        check("drain", 64'(q.size()), 64'd0);
        check("mid_wait_reset_seen", 64'(mid_done), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pepo_control_unit.md
PEPO_CONTROL_UNIT -- requirements
Module: pepo_control_unit

Interface
REQ-001 SHALL have parameter UWORD_W, default 48, microinstruction width (34 datapath bits + 14 sequencing bits).
REQ-002 SHALL have parameter STATES, default 64, microstore depth (6-bit state number).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 IR_OUT  input  32  current instruction register contents.
REQ-006 MOC  input  1  memory operation complete from RAM.
REQ-007 COND  input  1  condition tester result for IR_OUT[31:28] against flags.
REQ-008 LSM_DETECT  input  1  IR holds a load/store-multiple.
REQ-009 LSM_END  input  1  register list of LSM exhausted.
REQ-010 cu_datapath  output  34  registered datapath control word.

Function
REQ-011 SHALL be a microprogrammed sequencer: 6-bit state register, 64-entry constant microstore, next-state logic, registered control register CTL_REG_CUI.
REQ-012 cu_datapath bit map SHALL be fixed: [0] RF_LD, [1] IR_LD, [2] MAR_LD, [3] MDR_LD, [4] RW (1=read), [5] MOV, [6] FR_LD, [10:7] ALU_OP, [12:11] MA, [14:13] MB, [16:15] MC, [17] MD, [18] ME, [19] MF, [20] MG, [21] MH, [22] MI, [24:23] DSIZE (00 byte, 01 half, 10 word), [33:25] reserved, driven 0.
REQ-013 Microinstruction sequencing fields SHALL be: N[2:0] mode, INV (invert condition), CR[7:0] jump target (low 6 bits used).
REQ-014 N=000: next = state+1; 001: next = CR; 010: next = decoder(IR_OUT); 011: next = CR if (COND XOR INV) else state+1; 100: hold state while (MOC XOR INV)=0, else state+1; 101: next = CR if LSM_END else state+1.
REQ-015 Decoder (combinational): if COND=0 -> state 1; IR[27:25]=000/001 -> 10; 010/011 -> 20; 100 with LSM_DETECT=1 -> 40; 101 -> 30 (IR[24]=1 -> 31); otherwise -> 1.
REQ-016 Fixed states: 0 reset/idle (all controls 0, next 1); 1 MAR<-PC; 2 PC<-PC+4, MOV=1 RW=1 DSIZE=10; 3 MOC wait, IR_LD on exit; 4 decode (N=010).
REQ-017 Every execute routine SHALL end with N=001, CR=1 (return to fetch).
REQ-018 CTL_REG_CUI SHALL load microstore[next] each rising edge; cu_datapath = CTL_REG_CUI[33:0]; one-cycle latency from state selection to outputs.
REQ-019 CTL_REG_CUI[29:24] mirror SHALL NOT be required; current state available as internal signal state_q[5:0] for monitors.
REQ-020 MOC wait SHALL keep cu_datapath stable (MOV held) until MOC=1 sampled.
REQ-021 state+1 from 63 SHALL wrap to 0.
REQ-022 MOC and COND asserted together in a wait state: MOC governs, COND ignored.

Reset
REQ-023 RESET=0 SHALL force state_q=0 and CTL_REG_CUI=0 (cu_datapath=0) immediately, independent of CLK, including mid-memory-wait.
REQ-024 First rising edge after RESET=1 SHALL enter state 1.

Structure
REQ-025 Shared package SHALL hold cu_datapath bit-index constants, N-mode encodings, state-number constants, microstore table.
REQ-026 One sub-module natural: pepo_next_state (mode mux + decoder); microstore and registers in top.

Verification
REQ-027 RESET low then high, IR=0 -> cycle1 state 1 MAR_LD=1, cycle2 state 2 MOV=1 RW=1 DSIZE=10.
REQ-028 State 3 with MOC=0 for 5 cycles then 1 -> state held 5 cycles, IR_LD=1 on exit, state 4.
REQ-029 IR=32'hE2811001, COND=1 at decode -> state 10, RF_LD=1 in routine, return to state 1.
REQ-030 IR=32'h0A000002, COND=0 at decode -> next state 1, no RF_LD/FR_LD asserted.
REQ-031 LSM (IR[27:25]=100, LSM_DETECT=1), LSM_END=0 3 iterations then 1 -> loop 3 times, exit to CR target.
REQ-032 RESET=0 asserted in state 3 -> cu_datapath=0 same cycle, restart at state 1.
